id_ex_stage: RTL and testbench

- ID/EX pipeline register plus operand-forwarding network, sitting directly upstream of the execute-stage ALU.
- Captures decoded operands and control each cycle, resolves RAW hazards by forwarding from MEM/WB, and drives the ALU's sel/A/B.
- Detects load-use hazards, inserts a bubble and requests a decode stall.
- Counts inserted bubbles for performance debug.

---
 rtl/id_ex_stage.sv | 159 +++++++++++++++
 tb/tb_id_ex_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use bubble
// insertion and a saturating bubble counter for performance debug.
module id_ex_stage #(
    parameter int WIDTH     = 32,
    parameter int REG_ADDR  = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [WIDTH-1:0]     id_rs_data,
    input  logic [WIDTH-1:0]     id_rt_data,
    input  logic [WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR-1:0]  id_rs,
    input  logic [REG_ADDR-1:0]  id_rt,
    input  logic [REG_ADDR-1:0]  id_dest,
    input  logic                 id_rt_used,
    input  logic [2:0]           id_alu_sel,
    input  logic                 id_alu_src,
    input  logic                 id_reg_write,
    input  logic                 id_mem_read,
    input  logic                 id_mem_write,
    input  logic                 id_mem_to_reg,
    input  logic                 flush,
    input  logic                 mem_reg_write,
    input  logic [REG_ADDR-1:0]  mem_rd,
    input  logic [WIDTH-1:0]     mem_alu_result,
    input  logic                 wb_reg_write,
    input  logic [REG_ADDR-1:0]  wb_rd,
    input  logic [WIDTH-1:0]     wb_result,
    output logic [2:0]           alu_sel,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [WIDTH-1:0]     ex_store_data,
    output logic [REG_ADDR-1:0]  ex_dest,
    output logic                 ex_valid,
    output logic                 ex_reg_write,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic                 ex_mem_to_reg,
    output logic                 load_use_stall,
    output logic [CNT_WIDTH-1:0] bubble_count
);

    localparam logic [REG_ADDR-1:0]  REG_ZERO = {REG_ADDR{1'b0}};
    localparam logic [WIDTH-1:0]     DATA_ZERO = {WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);

    logic                 ex_valid_r;
    logic                 ex_reg_write_r;
    logic                 ex_mem_read_r;
    logic                 ex_mem_write_r;
    logic                 ex_mem_to_reg_r;
    logic                 alu_src_r;
    logic [2:0]           alu_sel_r;
    logic [WIDTH-1:0]     rs_data_r;
    logic [WIDTH-1:0]     rt_data_r;
    logic [WIDTH-1:0]     imm_r;
    logic [REG_ADDR-1:0]  rs_r;
    logic [REG_ADDR-1:0]  rt_r;
    logic [REG_ADDR-1:0]  dest_r;
    logic [CNT_WIDTH-1:0] bubble_count_r;

    logic                 load_use_stall_s;
    logic                 rt_hit_s;
    logic [WIDTH-1:0]     fwd_rs_s;
    logic [WIDTH-1:0]     fwd_rt_s;

    // Load in EX whose destination feeds the instruction now in decode.
    always_comb begin
        rt_hit_s         = id_rt_used & (ex_mem_read_r ? (dest_r == id_rt) : 1'b0);
        load_use_stall_s = id_valid & ex_valid_r & ex_mem_read_r & (dest_r != REG_ZERO)
                         & ((dest_r == id_rs) | rt_hit_s);
    end

    // Pipeline register: flush beats stall; both load a bubble and hold data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_r      <= 1'b0;
            ex_reg_write_r  <= 1'b0;
            ex_mem_read_r   <= 1'b0;
            ex_mem_write_r  <= 1'b0;
            ex_mem_to_reg_r <= 1'b0;
            alu_src_r       <= 1'b0;
            alu_sel_r       <= 3'b000;
            rs_data_r       <= DATA_ZERO;
            rt_data_r       <= DATA_ZERO;
            imm_r           <= DATA_ZERO;
            rs_r            <= REG_ZERO;
            rt_r            <= REG_ZERO;
            dest_r          <= REG_ZERO;
        end else if (flush || load_use_stall_s) begin
            ex_valid_r      <= 1'b0;
            ex_reg_write_r  <= 1'b0;
            ex_mem_read_r   <= 1'b0;
            ex_mem_write_r  <= 1'b0;
            ex_mem_to_reg_r <= 1'b0;
        end else begin
            ex_valid_r      <= id_valid;
            ex_reg_write_r  <= id_reg_write & id_valid;
            ex_mem_read_r   <= id_mem_read & id_valid;
            ex_mem_write_r  <= id_mem_write & id_valid;
            ex_mem_to_reg_r <= id_mem_to_reg & id_valid;
            alu_src_r       <= id_alu_src;
            alu_sel_r       <= id_alu_sel;
            rs_data_r       <= id_rs_data;
            rt_data_r       <= id_rt_data;
            imm_r           <= id_imm;
            rs_r            <= id_rs;
            rt_r            <= id_rt;
            dest_r          <= id_dest;
        end
    end

    // Saturating count of bubbles caused by load-use (flushed ones excluded).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_count_r <= CNT_ZERO;
        end else if (load_use_stall_s && !flush && (bubble_count_r != CNT_MAX)) begin
            bubble_count_r <= bubble_count_r + CNT_ONE;
        end
    end

    // Forwarding muxes: MEM over WB over register file; r0 never forwarded.
    always_comb begin
        fwd_rs_s = rs_data_r;
        fwd_rt_s = rt_data_r;
        if (mem_reg_write && (mem_rd != REG_ZERO) && (mem_rd == rs_r)) begin
            fwd_rs_s = mem_alu_result;
        end else if (wb_reg_write && (wb_rd != REG_ZERO) && (wb_rd == rs_r)) begin
            fwd_rs_s = wb_result;
        end else begin
            fwd_rs_s = rs_data_r;
        end
        if (mem_reg_write && (mem_rd != REG_ZERO) && (mem_rd == rt_r)) begin
            fwd_rt_s = mem_alu_result;
        end else if (wb_reg_write && (wb_rd != REG_ZERO) && (wb_rd == rt_r)) begin
            fwd_rt_s = wb_result;
        end else begin
            fwd_rt_s = rt_data_r;
        end
    end

    assign alu_sel        = alu_sel_r;
    assign alu_a          = fwd_rs_s;
    assign alu_b          = alu_src_r ? imm_r : fwd_rt_s;
    assign ex_store_data  = fwd_rt_s;
    assign ex_dest        = dest_r;
    assign ex_valid       = ex_valid_r;
    assign ex_reg_write   = ex_reg_write_r;
    assign ex_mem_read    = ex_mem_read_r;
    assign ex_mem_write   = ex_mem_write_r;
    assign ex_mem_to_reg  = ex_mem_to_reg_r;
    assign load_use_stall = load_use_stall_s;
    assign bubble_count   = bubble_count_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: scoreboard of expected EX-stage outputs,
// plus a second instance with a 2-bit bubble counter for saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_rs_data = 32'h0, id_rt_data = 32'h0, id_imm = 32'h0;
    logic [4:0]  id_rs = 5'd0, id_rt = 5'd0, id_dest = 5'd0;
    logic        id_rt_used = 1'b0;
    logic [2:0]  id_alu_sel = 3'b000;
    logic        id_alu_src = 1'b0;
    logic        id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0, id_mem_to_reg = 1'b0;
    logic        flush = 1'b0;
    logic        mem_reg_write = 1'b0;
    logic [4:0]  mem_rd = 5'd0;
    logic [31:0] mem_alu_result = 32'h0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_result = 32'h0;

    logic [2:0]  alu_sel;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic        load_use_stall;
    logic [15:0] bubble_count;

    logic [2:0]  d2_alu_sel;
    logic [31:0] d2_alu_a, d2_alu_b, d2_ex_store_data;
    logic [4:0]  d2_ex_dest;
    logic        d2_ex_valid, d2_ex_reg_write, d2_ex_mem_read, d2_ex_mem_write, d2_ex_mem_to_reg;
    logic        d2_load_use_stall;
    logic [1:0]  d2_bubble_count;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest), .id_rt_used(id_rt_used),
        .id_alu_sel(id_alu_sel), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .flush(flush), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .mem_alu_result(mem_alu_result), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_result(wb_result),
        .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .load_use_stall(load_use_stall), .bubble_count(bubble_count)
    );

    id_ex_stage #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest), .id_rt_used(id_rt_used),
        .id_alu_sel(id_alu_sel), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .flush(flush), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .mem_alu_result(mem_alu_result), .wb_reg_write(wb_reg_write),
        .wb_rd(wb_rd), .wb_result(wb_result),
        .alu_sel(d2_alu_sel), .alu_a(d2_alu_a), .alu_b(d2_alu_b),
        .ex_store_data(d2_ex_store_data), .ex_dest(d2_ex_dest), .ex_valid(d2_ex_valid),
        .ex_reg_write(d2_ex_reg_write), .ex_mem_read(d2_ex_mem_read),
        .ex_mem_write(d2_ex_mem_write), .ex_mem_to_reg(d2_ex_mem_to_reg),
        .load_use_stall(d2_load_use_stall), .bubble_count(d2_bubble_count)
    );

    typedef struct {
        string       tag;
        logic [2:0]  sel;
        logic [31:0] a, b, st;
        logic [4:0]  dest;
        logic [4:0]  ctl;   // {valid, reg_write, mem_read, mem_write, mem_to_reg}
        logic [15:0] bc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [4:0] C_NONE = 5'b00000;
    localparam logic [4:0] C_ALU  = 5'b11000;
    localparam logic [4:0] C_LW   = 5'b11101;
    localparam logic [4:0] C_SW   = 5'b10010;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [2:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] st, input logic [4:0] dest,
                        input logic [4:0] ctl, input logic [15:0] bc);
        exp_t e;
        e.tag = tag; e.sel = sel; e.a = a; e.b = b; e.st = st;
        e.dest = dest; e.ctl = ctl; e.bc = bc;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk($sformatf("%s.alu_sel", e.tag), 64'(alu_sel), 64'(e.sel));
            chk($sformatf("%s.alu_a", e.tag), 64'(alu_a), 64'(e.a));
            chk($sformatf("%s.alu_b", e.tag), 64'(alu_b), 64'(e.b));
            chk($sformatf("%s.store", e.tag), 64'(ex_store_data), 64'(e.st));
            chk($sformatf("%s.dest", e.tag), 64'(ex_dest), 64'(e.dest));
            chk($sformatf("%s.ctl", e.tag),
                64'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 64'(e.ctl));
            chk($sformatf("%s.bubbles", e.tag), 64'(bubble_count), 64'(e.bc));
        end
    endtask

    task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dest, input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic [31:0] imm, input logic rtu, input logic [2:0] sel,
                         input logic src, input logic rw, input logic mr, input logic mw,
                         input logic m2r);
        id_valid = v; id_rs = rs; id_rt = rt; id_dest = dest;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_rt_used = rtu;
        id_alu_sel = sel; id_alu_src = src;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    // LW r8, 4(r1) with r1=0x200 and stale rt value 0x77
    task automatic issue_lw();
        issue(1'b1, 5'd1, 5'd8, 5'd8, 32'h200, 32'h77, 32'h4, 1'b0, 3'b000, 1'b1,
              1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    // ADD r10, r8, r2 -- consumes the load result
    task automatic issue_dep();
        issue(1'b1, 5'd8, 5'd2, 5'd10, 32'h1, 32'h2, 32'h0, 1'b1, 3'b000, 1'b0,
              1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        @(negedge clk); #1;
        push("reset", 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, C_NONE, 16'd0);
        check_out();
        chk("reset.stall", 64'(load_use_stall), 64'd0);

        // Capture an instruction, then reset asynchronously mid-cycle
        @(negedge clk);
        rst = 1'b0;
        issue(1'b1, 5'd1, 5'd2, 5'd9, 32'd11, 32'd22, 32'h0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        push("pre_rst", 3'b000, 32'd11, 32'd22, 32'd22, 5'd9, C_ALU, 16'd0);
        check_out();
        #2 rst = 1'b1;
        #1;
        push("async_rst", 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, C_NONE, 16'd0);
        check_out();

        // Release and capture ADD 5 + 7
        @(negedge clk);
        rst = 1'b0;
        issue(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        push("t1_add", 3'b000, 32'd5, 32'd7, 32'd7, 5'd3, C_ALU, 16'd0);
        check_out();

        // MEM beats WB, then WB alone
        @(negedge clk);
        issue(1'b1, 5'd3, 5'd0, 5'd6, 32'h33, 32'h44, 32'h0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        mem_reg_write = 1'b1; mem_rd = 5'd3; mem_alu_result = 32'hAA;
        wb_reg_write = 1'b1; wb_rd = 5'd3; wb_result = 32'hBB;
        step();
        push("t2_mem", 3'b010, 32'hAA, 32'h44, 32'h44, 5'd6, C_ALU, 16'd0);
        check_out();
        @(negedge clk);
        mem_reg_write = 1'b0;
        #1;
        push("t2_wb", 3'b010, 32'hBB, 32'h44, 32'h44, 5'd6, C_ALU, 16'd0);
        check_out();

        // r0 is never forwarded
        @(negedge clk);
        issue(1'b1, 5'd0, 5'd5, 5'd7, 32'h0, 32'h55, 32'h0, 1'b1, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        mem_reg_write = 1'b1; mem_rd = 5'd0; mem_alu_result = 32'hFFFF_FFFF;
        wb_reg_write = 1'b0;
        step();
        push("t3_r0", 3'b100, 32'h0, 32'h55, 32'h55, 5'd7, C_ALU, 16'd0);
        check_out();

        // Store: B from immediate, store data forwarded from WB
        @(negedge clk);
        mem_reg_write = 1'b0;
        wb_reg_write = 1'b1; wb_rd = 5'd4; wb_result = 32'h1234;
        issue(1'b1, 5'd2, 5'd4, 5'd0, 32'h100, 32'h9, 32'h10, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        push("t4_sw", 3'b000, 32'h100, 32'h10, 32'h1234, 5'd0, C_SW, 16'd0);
        check_out();

        // Load-use: stall, bubble, then the dependent instruction issues
        @(negedge clk);
        wb_reg_write = 1'b0;
        issue_lw();
        step();
        push("t5_lw", 3'b000, 32'h200, 32'h4, 32'h77, 5'd8, C_LW, 16'd0);
        check_out();
        @(negedge clk);
        issue_dep();
        #1 chk("t5_stall", 64'(load_use_stall), 64'd1);
        step();
        push("t5_bubble", 3'b000, 32'h200, 32'h4, 32'h77, 5'd8, C_NONE, 16'd1);
        check_out();
        chk("t5_stall_clear", 64'(load_use_stall), 64'd0);
        step();
        push("t5_dep", 3'b000, 32'h1, 32'h2, 32'h2, 5'd10, C_ALU, 16'd1);
        check_out();

        // rt matches but is unused: no stall
        @(negedge clk);
        issue_lw();
        step();
        push("t5b_lw", 3'b000, 32'h200, 32'h4, 32'h77, 5'd8, C_LW, 16'd1);
        check_out();
        @(negedge clk);
        issue(1'b1, 5'd3, 5'd8, 5'd8, 32'h3, 32'h88, 32'h5, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk("t5b_nostall", 64'(load_use_stall), 64'd0);
        step();
        push("t5b_addi", 3'b000, 32'h3, 32'h5, 32'h88, 5'd8, C_ALU, 16'd1);
        check_out();

        // Flush with a concurrent load-use: bubble, counter unchanged
        @(negedge clk);
        issue_lw();
        step();
        push("t6_lw", 3'b000, 32'h200, 32'h4, 32'h77, 5'd8, C_LW, 16'd1);
        check_out();
        @(negedge clk);
        issue_dep();
        flush = 1'b1;
        #1 chk("t6_stall_flush", 64'(load_use_stall), 64'd1);
        step();
        push("t6_flush", 3'b000, 32'h200, 32'h4, 32'h77, 5'd8, C_NONE, 16'd1);
        check_out();

        // Saturation: five load-use bubbles on a 2-bit counter
        @(negedge clk);
        flush = 1'b0;
        rst = 1'b1;
        #1;
        chk("sat_reset_bc", 64'(bubble_count), 64'd0);
        chk("sat_reset_bc2", 64'(d2_bubble_count), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rst = 1'b0;
            issue_lw();
            step();
            push($sformatf("sat_lw%0d", i), 3'b000, 32'h200, 32'h4, 32'h77, 5'd8, C_LW, 16'(i));
            check_out();
            @(negedge clk);
            issue_dep();
            #1 chk($sformatf("sat_stall%0d", i), 64'(load_use_stall), 64'd1);
            step();
            push($sformatf("sat_bub%0d", i), 3'b000, 32'h200, 32'h4, 32'h77, 5'd8, C_NONE, 16'(i + 1));
            check_out();
            chk($sformatf("sat_bc2_%0d", i), 64'(d2_bubble_count), 64'((i + 1 > 3) ? 3 : i + 1));
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
